// File: rtl/bnn_pkg.sv
// Shared types for the binarised-layer sequencer.
// Used by bnn_layer_seq and bnn_act_collector.
package bnn_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } bnn_seq_state_t;

   localparam int BNN_X_W = 4;
   localparam int BNN_W_W = 4;
   localparam int BNN_B_W = 4;

   typedef struct packed {
      logic [3:0] bias;
      logic [3:0] weight;
   } bnn_wbyte_t;

endpackage

// File: rtl/bnn_act_collector.sv
// Gathers neuron result bits into the layer output vector.
// Optional running popcount when BNN_LAYER_POPCNT_EN is defined.
module bnn_act_collector
   import bnn_pkg::*;
#(
   parameter int N_NEURONS = 8,
   localparam int CW = $clog2(N_NEURONS + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr_i,
   input  logic                 cap_i,
   input  logic                 bit_i,
   output logic [N_NEURONS-1:0] act_o,
`ifdef BNN_LAYER_POPCNT_EN
   output logic [CW-1:0]        popcnt_o,
`endif
   output logic [CW-1:0]        cnt_o
);

   logic [N_NEURONS-1:0] act_q, act_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 cap_ok;

   // the counter saturates at N_NEURONS, so a stray strobe cannot wrap
   assign cap_ok = cap_i && (cnt_q < CW'(N_NEURONS));

   always_comb begin
      act_d = act_q;
      cnt_d = cnt_q;
      if (clr_i) begin
         act_d = '0;
         cnt_d = '0;
      end else if (cap_ok) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            if (cnt_q == CW'(i)) act_d[i] = bit_i;
         end
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_q <= '0;
         cnt_q <= '0;
      end else begin
         act_q <= act_d;
         cnt_q <= cnt_d;
      end
   end

`ifdef BNN_LAYER_POPCNT_EN
   logic [CW-1:0] pop_q, pop_d;

   always_comb begin
      pop_d = pop_q;
      if (clr_i) pop_d = '0;
      else if (cap_ok) pop_d = pop_q + CW'(bit_i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pop_q <= '0;
      else        pop_q <= pop_d;
   end

   assign popcnt_o = pop_q;
`endif

   assign act_o = act_q;
   assign cnt_o = cnt_q;

endmodule

// File: rtl/bnn_layer_seq.sv
// Streams one binarised layer through a single XNOR/popcount/bias neuron.
// Define BNN_LAYER_POPCNT_EN to add the out_popcnt output.
module bnn_layer_seq
   import bnn_pkg::*;
#(
   parameter int N_NEURONS = 8,
   localparam int CW = $clog2(N_NEURONS + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BNN_X_W-1:0]   in_x,
   input  logic                 w_valid,
   output logic                 w_ready,
   input  logic [7:0]           w_data,
   output logic [BNN_X_W-1:0]   neu_x,
   output logic [BNN_W_W-1:0]   neu_w,
   output logic [BNN_B_W-1:0]   neu_b,
   input  logic                 neu_result,
   output logic                 out_valid,
   input  logic                 out_ready,
`ifdef BNN_LAYER_POPCNT_EN
   output logic [CW-1:0]        out_popcnt,
`endif
   output logic [N_NEURONS-1:0] out_act
);

   bnn_seq_state_t state_q, state_d;

   logic [BNN_X_W-1:0] neu_x_q, neu_x_d;
   logic [BNN_W_W-1:0] neu_w_q, neu_w_d;
   logic [BNN_B_W-1:0] neu_b_q, neu_b_d;
   logic [CW-1:0]      issue_q, issue_d;
   logic               pend_q, pend_d;

   logic               cap;
   logic               clr;
   logic [CW-1:0]      cap_cnt;
   bnn_wbyte_t         wb;

   assign wb = bnn_wbyte_t'(w_data);

   always_comb begin
      state_d   = state_q;
      neu_x_d   = neu_x_q;
      neu_w_d   = neu_w_q;
      neu_b_d   = neu_b_q;
      issue_d   = issue_q;
      pend_d    = pend_q;
      in_ready  = 1'b0;
      w_ready   = 1'b0;
      out_valid = 1'b0;
      cap       = 1'b0;
      clr       = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               neu_x_d = in_x;
               issue_d = '0;
               pend_d  = 1'b0;
               clr     = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            w_ready = issue_q < CW'(N_NEURONS);
            // result of last cycle's issue is on neu_result now
            cap    = pend_q;
            pend_d = 1'b0;
            if (w_valid && w_ready) begin
               neu_w_d = wb.weight;
               neu_b_d = wb.bias;
               pend_d  = 1'b1;
               issue_d = issue_q + 1'b1;
            end
            if (cap_cnt == CW'(N_NEURONS)) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         neu_x_q <= '0;
         neu_w_q <= '0;
         neu_b_q <= '0;
         issue_q <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         neu_x_q <= neu_x_d;
         neu_w_q <= neu_w_d;
         neu_b_q <= neu_b_d;
         issue_q <= issue_d;
         pend_q  <= pend_d;
      end
   end

   bnn_act_collector #(
      .N_NEURONS(N_NEURONS)
   ) u_coll (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (clr),
      .cap_i   (cap),
      .bit_i   (neu_result),
      .act_o   (out_act),
`ifdef BNN_LAYER_POPCNT_EN
      .popcnt_o(out_popcnt),
`endif
      .cnt_o   (cap_cnt)
   );

   assign neu_x = neu_x_q;
   assign neu_w = neu_w_q;
   assign neu_b = neu_b_q;

endmodule

// File: tb/tb_bnn_layer_seq.sv
// Self-checking bench for bnn_layer_seq with a behavioural neuron and layer model.
// Define BNN_LAYER_POPCNT_EN to also check out_popcnt.
module tb_bnn_layer_seq;

   localparam int N  = 4;
   localparam int CW = $clog2(N + 1);

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   in_x;
   logic         w_valid;
   logic         w_ready;
   logic [7:0]   w_data;
   logic [3:0]   neu_x;
   logic [3:0]   neu_w;
   logic [3:0]   neu_b;
   logic         neu_result;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_act;
`ifdef BNN_LAYER_POPCNT_EN
   logic [CW-1:0] out_popcnt;
`endif

   int   total = 0;
   int   bad   = 0;
   int   neu_mode;
   logic [7:0] wbytes [N];

   bnn_layer_seq #(
      .N_NEURONS(N)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .w_data    (w_data),
      .neu_x     (neu_x),
      .neu_w     (neu_w),
      .neu_b     (neu_b),
      .neu_result(neu_result),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef BNN_LAYER_POPCNT_EN
      .out_popcnt(out_popcnt),
`endif
      .out_act   (out_act)
   );

   always #5 clk = ~clk;

   // mode 0: result = weight bit 0; mode 1: xnor-popcount against bias
   function automatic logic neuron_ref(input int m, input logic [3:0] x,
                                       input logic [3:0] w, input logic [3:0] b);
      int ones;
      if (m == 0) return w[0];
      ones = $countones(~(x ^ w));
      return (ones * 2) >= int'(b);
   endfunction

   assign neu_result = neuron_ref(neu_mode, neu_x, neu_w, neu_b);

   function automatic logic [N-1:0] layer_ref(input logic [3:0] x);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++)
         r[i] = neuron_ref(neu_mode, x, wbytes[i][3:0], wbytes[i][7:4]);
      return r;
   endfunction

   // Starts at a negedge with the DUT idle; returns at the first negedge showing out_valid.
   task automatic drive_layer(input logic [3:0] x, input int wmode,
                              output int lat, output int last_hs,
                              output int n_hs, output bit extra_hs);
      int cyc;
      int idx;
      bit hs;
      cyc = 0; idx = 0; lat = -1; last_hs = -1; n_hs = 0; extra_hs = 0;
      in_x = x;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      while (lat < 0 && cyc < 100) begin
         if (out_valid) begin
            lat = cyc;
         end else begin
            case (wmode)
               0:       w_valid = idx < N;
               1:       w_valid = (idx < N) && (cyc % 2 == 1);
               2:       w_valid = (idx < N) && ($urandom_range(0, 2) != 0);
               default: w_valid = 1'b1;
            endcase
            w_data = (idx < N) ? wbytes[idx] : 8'hE0;
            hs = w_valid && w_ready;
            if (hs && idx >= N) extra_hs = 1;
            if (hs) begin
               last_hs = cyc;
               n_hs++;
               idx++;
            end
            @(negedge clk);
            cyc++;
         end
      end
      w_valid = 1'b0;
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if (in_ready !== 1'b1 || w_ready !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_hs: in_ready=%b w_ready=%b out_valid=%b want 1 0 0",
                  in_ready, w_ready, out_valid);
      end
      total++;
      if (neu_x !== 4'h0 || neu_w !== 4'h0 || neu_b !== 4'h0 || out_act !== '0) begin
         bad++;
         $display("FAIL reset_regs: x=%h w=%h b=%h act=%b want all 0",
                  neu_x, neu_w, neu_b, out_act);
      end
`ifdef BNN_LAYER_POPCNT_EN
      total++;
      if (out_popcnt !== '0) begin
         bad++;
         $display("FAIL reset_pop: got %0d want 0", out_popcnt);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_reset: in_ready=%b out_valid=%b", in_ready, out_valid);
      end
   endtask

   task automatic test_held_valid();
      int lat, lhs, nhs;
      bit ex;
      logic [N-1:0] exp;
      neu_mode = 0;
      wbytes[0] = 8'h01; wbytes[1] = 8'h00; wbytes[2] = 8'h11; wbytes[3] = 8'h01;
      exp = layer_ref(4'hA);
      drive_layer(4'hA, 0, lat, lhs, nhs, ex);
      total++;
      if (lat !== N + 2) begin
         bad++;
         $display("FAIL held_latency: got %0d want %0d", lat, N + 2);
      end
      total++;
      if (out_act !== exp || exp !== 4'b1101) begin
         bad++;
         $display("FAIL held_act: got %b want %b", out_act, exp);
      end
      total++;
      if (neu_x !== 4'hA || neu_w !== wbytes[3][3:0] || neu_b !== wbytes[3][7:4]) begin
         bad++;
         $display("FAIL held_neu: x=%h w=%h b=%h want a %h %h",
                  neu_x, neu_w, neu_b, wbytes[3][3:0], wbytes[3][7:4]);
      end
`ifdef BNN_LAYER_POPCNT_EN
      total++;
      if (out_popcnt !== CW'($countones(exp))) begin
         bad++;
         $display("FAIL held_pop: got %0d want %0d", out_popcnt, $countones(exp));
      end
`endif
      release_out();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL held_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_gapped_valid();
      int lat, lhs, nhs;
      bit ex;
      logic [N-1:0] exp;
      neu_mode = 0;
      exp = layer_ref(4'hA);
      drive_layer(4'hA, 1, lat, lhs, nhs, ex);
      total++;
      if (out_act !== exp) begin
         bad++;
         $display("FAIL gap_act: got %b want %b", out_act, exp);
      end
      total++;
      if (nhs !== N || lat !== lhs + 3) begin
         bad++;
         $display("FAIL gap_timing: hs=%0d lat=%0d want hs=%0d lat=%0d", nhs, lat, N, lhs + 3);
      end
      release_out();
   endtask

   task automatic test_done_hold();
      int lat, lhs, nhs;
      bit ex;
      logic [N-1:0] exp;
      neu_mode = 0;
      wbytes[0] = 8'h30; wbytes[1] = 8'h51; wbytes[2] = 8'h71; wbytes[3] = 8'h90;
      exp = layer_ref(4'h3);
      drive_layer(4'h3, 0, lat, lhs, nhs, ex);
      in_x = 4'hC;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || out_act !== exp || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL done_hold[%0d]: ov=%b act=%b ir=%b want 1 %b 0",
                     i, out_valid, out_act, in_ready, exp);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || neu_x !== 4'h3) begin
         bad++;
         $display("FAIL done_exit: ov=%b ir=%b x=%h want 0 1 3", out_valid, in_ready, neu_x);
      end
   endtask

   task automatic test_reset_midrun();
      int lat, lhs, nhs;
      bit ex;
      logic [N-1:0] exp;
      neu_mode = 0;
      in_x = 4'h9;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      w_valid = 1'b1;
      w_data = 8'h71;
      @(negedge clk);
      w_data = 8'h33;
      @(negedge clk);
      w_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      total++;
      if (in_ready !== 1'b1 || w_ready !== 1'b0 || out_valid !== 1'b0 || out_act !== '0) begin
         bad++;
         $display("FAIL midrun_reset_hs: ir=%b wr=%b ov=%b act=%b",
                  in_ready, w_ready, out_valid, out_act);
      end
      total++;
      if (neu_x !== 4'h0 || neu_w !== 4'h0 || neu_b !== 4'h0) begin
         bad++;
         $display("FAIL midrun_reset_neu: x=%h w=%h b=%h want 0", neu_x, neu_w, neu_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N; i++) wbytes[i] = 8'hF1;
      exp = layer_ref(4'h5);
      drive_layer(4'h5, 0, lat, lhs, nhs, ex);
      total++;
      if (out_act !== exp || exp !== 4'hF || lat !== N + 2) begin
         bad++;
         $display("FAIL after_reset_layer: act=%b lat=%0d want %b %0d", out_act, lat, exp, N + 2);
      end
      release_out();
   endtask

   task automatic test_extra_byte();
      int lat, lhs, nhs;
      bit ex;
      logic [N-1:0] exp;
      neu_mode = 0;
      wbytes[0] = 8'h10; wbytes[1] = 8'h21; wbytes[2] = 8'h40; wbytes[3] = 8'h83;
      exp = layer_ref(4'h6);
      drive_layer(4'h6, 3, lat, lhs, nhs, ex);
      total++;
      if (ex !== 1'b0 || nhs !== N) begin
         bad++;
         $display("FAIL extra_hs: extra=%b hs=%0d want 0 %0d", ex, nhs, N);
      end
      total++;
      if (neu_w !== 4'h3 || neu_b !== 4'h8 || out_act !== exp) begin
         bad++;
         $display("FAIL extra_keep: w=%h b=%h act=%b want 3 8 %b", neu_w, neu_b, out_act, exp);
      end
      total++;
      if (w_ready !== 1'b0) begin
         bad++;
         $display("FAIL extra_wready: got %b want 0", w_ready);
      end
      release_out();
   endtask

   task automatic test_random();
      int lat, lhs, nhs;
      bit ex;
      logic [3:0] x;
      logic [N-1:0] exp;
      neu_mode = 1;
      for (int it = 0; it < 12; it++) begin
         x = 4'($urandom);
         for (int i = 0; i < N; i++) wbytes[i] = 8'($urandom);
         exp = layer_ref(x);
         drive_layer(x, (it % 3 == 0) ? 0 : 2, lat, lhs, nhs, ex);
         total++;
         if (out_act !== exp || lat !== lhs + 3 || lat < N + 2) begin
            bad++;
            $display("FAIL rand[%0d]: act=%b lat=%0d want %b lat=%0d",
                     it, out_act, lat, exp, lhs + 3);
         end
`ifdef BNN_LAYER_POPCNT_EN
         total++;
         if (out_popcnt !== CW'($countones(exp))) begin
            bad++;
            $display("FAIL rand_pop[%0d]: got %0d want %0d", it, out_popcnt, $countones(exp));
         end
`endif
         repeat ($urandom_range(0, 3)) @(negedge clk);
         release_out();
      end
   endtask

   initial begin
      clk       = 1'b0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_x      = 4'h0;
      w_valid   = 1'b0;
      w_data    = 8'h00;
      out_ready = 1'b0;
      neu_mode  = 0;
      for (int i = 0; i < N; i++) wbytes[i] = 8'h00;
      test_reset();
      test_held_valid();
      test_gapped_valid();
      test_done_hold();
      test_reset_midrun();
      test_extra_byte();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
